// File: rtl/vmem_line_sched_pkg.sv
// Shared defaults, FSM state type and the saturating drop-counter helper
// for the capture line RAM ping-pong scheduler.
package vmem_line_sched_pkg;

  localparam int VMEM_DATA_W   = 12;
  localparam int VMEM_ADDR_W   = 9;
  localparam int VMEM_LINE_LEN = 320;
  localparam int DROP_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SKIP = 2'd2
  } state_e;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/vmem_line_sched.sv
// Ping-pong write scheduler for the two-bank capture line RAM: writes pixels
// into the current bank, commits full lines and hands them to readout in order.
module vmem_line_sched
  import vmem_line_sched_pkg::*;
#(
  parameter int DATA_W   = VMEM_DATA_W,
  parameter int ADDR_W   = VMEM_ADDR_W,
  parameter int LINE_LEN = VMEM_LINE_LEN
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_line_start,
  input  logic                i_vdata_valid,
  input  logic [DATA_W-1:0]   i_vdata,
  output logic                o_wr_en,
  output logic [ADDR_W:0]     o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic                o_line_rdy,
  output logic                o_rd_bank,
  input  logic                i_line_done,
  output logic [DROP_W-1:0]   o_drop_cnt,
  output logic                o_busy,
  output state_e              o_dbg_state
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_LEN - 1);

  // Readout handshake: o_line_rdy is a level meaning "bank o_rd_bank holds a
  // committed line"; a one-cycle i_line_done while it is high releases that
  // bank and advances o_rd_bank. A done pulse while o_line_rdy is low is ignored.

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [1:0]           full_q, full_d;
  logic [DROP_W-1:0]    drop_q, drop_d;
  logic                 commit_pend_q;
  logic                 commit_bank_q;
  logic                 wr_en_q;
  logic [ADDR_W:0]      wr_addr_q;
  logic [DATA_W-1:0]    wr_data_q;

  logic                 accept;
  logic                 commit;
  logic [CNT_W-1:0]     base;
  logic [ADDR_W-1:0]    acc_word;
  logic                 done_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_bank_d = wr_bank_q;
    drop_d    = drop_q;
    accept    = 1'b0;
    commit    = 1'b0;
    base      = cnt_q;
    acc_word  = cnt_q[ADDR_W-1:0];
    case (state_q)
      ST_IDLE, ST_SKIP: begin
        if (i_line_start) begin
          if (full_q[wr_bank_q]) begin
            state_d = ST_SKIP;
            drop_d  = sat_inc(drop_q);
          end else begin
            state_d = ST_FILL;
            cnt_d   = '0;
          end
        end
      end
      ST_FILL: begin
        // A restart abandons the short line but keeps the bank; the pixel
        // arriving with the restart becomes word 0 of the new line.
        if (i_line_start) begin
          base   = '0;
          drop_d = sat_inc(drop_q);
        end
        cnt_d = base;
        if (i_vdata_valid) begin
          accept   = 1'b1;
          acc_word = base[ADDR_W-1:0];
          cnt_d    = base + CNT_W'(1);
          if (base == LAST_WORD) begin
            commit    = 1'b1;
            wr_bank_d = ~wr_bank_q;
            state_d   = ST_IDLE;
            cnt_d     = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The commit lands one cycle after the last write so readout never sees a
  // bank before its final word is in the RAM.
  always_comb begin
    full_d    = full_q;
    rd_bank_d = rd_bank_q;
    done_ok   = i_line_done & full_q[rd_bank_q];
    if (commit_pend_q) full_d[commit_bank_q] = 1'b1;
    if (done_ok) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_q        <= '0;
      drop_q        <= '0;
      commit_pend_q <= 1'b0;
      commit_bank_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      drop_q        <= drop_d;
      commit_pend_q <= commit;
      if (commit) commit_bank_q <= wr_bank_q;
      wr_en_q       <= accept;
      if (accept) begin
        wr_addr_q <= {wr_bank_q, acc_word};
        wr_data_q <= i_vdata;
      end
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_line_rdy  = full_q[rd_bank_q];
  assign o_rd_bank   = rd_bank_q;
  assign o_drop_cnt  = drop_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_vmem_line_sched.sv
// Directed bench for vmem_line_sched with LINE_LEN=4: table of per-cycle
// vectors plus hand sequences for drop saturation and mid-line reset.
module tb_vmem_line_sched;
  import vmem_line_sched_pkg::*;

  localparam int DW = 12;
  localparam int AW = 9;
  localparam int LL = 4;

  logic          clk;
  logic          rst_n;
  logic          line_start;
  logic          vdata_valid;
  logic [DW-1:0] vdata;
  logic          line_done;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          line_rdy;
  logic          rd_bank;
  logic [7:0]    drop_cnt;
  logic          busy;
  state_e        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW+DW:0] exp_q[$];

  vmem_line_sched #(.DATA_W(DW), .ADDR_W(AW), .LINE_LEN(LL)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_line_start (line_start),
    .i_vdata_valid(vdata_valid),
    .i_vdata      (vdata),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_line_rdy   (line_rdy),
    .o_rd_bank    (rd_bank),
    .i_line_done  (line_done),
    .o_drop_cnt   (drop_cnt),
    .o_busy       (busy),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ls;
    logic          v;
    logic [DW-1:0] d;
    logic          ld;
    logic          e_wr_en;
    logic [AW:0]   e_addr;
    logic [DW-1:0] e_data;
    logic          e_rdy;
    logic          e_rdb;
    logic [7:0]    e_drop;
    logic          e_busy;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every observed write must match the oldest expected one
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {21'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_write", {19'd0, wr_addr, wr_data}, {19'd0, exp_q.pop_front()});
      end
    end
  end

  // driver: apply one cycle of inputs, sample just after the edge
  task automatic drive(input logic ls, input logic v, input logic [DW-1:0] d, input logic ld);
    @(negedge clk);
    line_start  = ls;
    vdata_valid = v;
    vdata       = d;
    line_done   = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic ls, input logic v, input logic [DW-1:0] d,
                         input logic ld, input logic we, input logic [AW:0] a,
                         input logic [DW-1:0] wd, input logic rdy, input logic rdb,
                         input logic [7:0] dr, input logic bz);
    vecs[i] = '{ls, v, d, ld, we, a, wd, rdy, rdb, dr, bz};
  endtask

  initial begin
    int exp_drop;
    string nm;

    //          ls v  d       ld we addr    data    rdy rdb drop bz
    set_vec( 0, 1, 0, 12'h0,  0, 0, 10'h000, 12'h000, 0, 0, 0, 1);
    set_vec( 1, 0, 1, 12'h1,  0, 1, 10'h000, 12'h001, 0, 0, 0, 1);
    set_vec( 2, 0, 1, 12'h2,  0, 1, 10'h001, 12'h002, 0, 0, 0, 1);
    set_vec( 3, 0, 1, 12'h3,  0, 1, 10'h002, 12'h003, 0, 0, 0, 1);
    set_vec( 4, 0, 1, 12'h4,  0, 1, 10'h003, 12'h004, 0, 0, 0, 0);
    set_vec( 5, 0, 0, 12'h0,  0, 0, 10'h003, 12'h004, 1, 0, 0, 0);
    set_vec( 6, 1, 0, 12'h0,  0, 0, 10'h003, 12'h004, 1, 0, 0, 1);
    set_vec( 7, 0, 1, 12'h5,  0, 1, 10'h200, 12'h005, 1, 0, 0, 1);
    set_vec( 8, 0, 1, 12'h6,  0, 1, 10'h201, 12'h006, 1, 0, 0, 1);
    set_vec( 9, 0, 1, 12'h7,  0, 1, 10'h202, 12'h007, 1, 0, 0, 1);
    set_vec(10, 0, 1, 12'h8,  0, 1, 10'h203, 12'h008, 1, 0, 0, 0);
    set_vec(11, 0, 0, 12'h0,  0, 0, 10'h203, 12'h008, 1, 0, 0, 0);
    set_vec(12, 1, 0, 12'h0,  0, 0, 10'h203, 12'h008, 1, 0, 1, 1);
    set_vec(13, 0, 1, 12'h9,  0, 0, 10'h203, 12'h008, 1, 0, 1, 1);
    set_vec(14, 0, 0, 12'h0,  1, 0, 10'h203, 12'h008, 1, 1, 1, 1);
    set_vec(15, 1, 0, 12'h0,  0, 0, 10'h203, 12'h008, 1, 1, 1, 1);
    set_vec(16, 0, 1, 12'hA,  0, 1, 10'h000, 12'h00A, 1, 1, 1, 1);
    set_vec(17, 0, 1, 12'hB,  0, 1, 10'h001, 12'h00B, 1, 1, 1, 1);
    set_vec(18, 1, 1, 12'hC,  0, 1, 10'h000, 12'h00C, 1, 1, 2, 1);
    set_vec(19, 0, 1, 12'hD,  0, 1, 10'h001, 12'h00D, 1, 1, 2, 1);
    set_vec(20, 0, 1, 12'hE,  0, 1, 10'h002, 12'h00E, 1, 1, 2, 1);
    set_vec(21, 0, 1, 12'hF,  0, 1, 10'h003, 12'h00F, 1, 1, 2, 0);
    set_vec(22, 0, 0, 12'h0,  1, 0, 10'h003, 12'h00F, 1, 0, 2, 0);
    set_vec(23, 0, 0, 12'h0,  1, 0, 10'h003, 12'h00F, 0, 1, 2, 0);
    set_vec(24, 0, 0, 12'h0,  1, 0, 10'h003, 12'h00F, 0, 1, 2, 0);

    rst_n = 1'b0; line_start = 1'b0; vdata_valid = 1'b0; vdata = '0; line_done = 1'b0;
    #12;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {22'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {20'd0, wr_data}, 32'd0);
    chk("rst_line_rdy", {31'd0, line_rdy}, 32'd0);
    chk("rst_rd_bank", {31'd0, rd_bank}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      if (vecs[i].e_wr_en) exp_q.push_back({vecs[i].e_addr, vecs[i].e_data});
      drive(vecs[i].ls, vecs[i].v, vecs[i].d, vecs[i].ld);
      nm = $sformatf("v%0d", i);
      chk({nm, "_wr_en"}, {31'd0, wr_en}, {31'd0, vecs[i].e_wr_en});
      chk({nm, "_addr"}, {22'd0, wr_addr}, {22'd0, vecs[i].e_addr});
      chk({nm, "_data"}, {20'd0, wr_data}, {20'd0, vecs[i].e_data});
      chk({nm, "_rdy"}, {31'd0, line_rdy}, {31'd0, vecs[i].e_rdy});
      chk({nm, "_rd_bank"}, {31'd0, rd_bank}, {31'd0, vecs[i].e_rdb});
      chk({nm, "_drop"}, {24'd0, drop_cnt}, {24'd0, vecs[i].e_drop});
      chk({nm, "_busy"}, {31'd0, busy}, {31'd0, vecs[i].e_busy});
    end

    // drop saturation: back-to-back line starts in bank 1, first one enters FILL
    exp_drop = 2;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0);
      if (i > 0) exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
      chk($sformatf("sat_drop_%0d", i), {24'd0, drop_cnt}, exp_drop);
    end
    chk("sat_final", {24'd0, drop_cnt}, 32'd255);
    chk("sat_busy", {31'd0, busy}, 32'd1);

    // two pixels into bank 1, then reset mid-line
    exp_q.push_back({10'h200, 12'h021});
    drive(1'b0, 1'b1, 12'h021, 1'b0);
    exp_q.push_back({10'h201, 12'h022});
    drive(1'b0, 1'b1, 12'h022, 1'b0);
    chk("pre_rst_addr", {22'd0, wr_addr}, 32'h201);
    @(negedge clk);
    vdata_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("mid_rst_addr", {22'd0, wr_addr}, 32'd0);
    chk("mid_rst_data", {20'd0, wr_data}, 32'd0);
    chk("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, '0, 1'b0);
    exp_q.push_back({10'h000, 12'h055});
    drive(1'b0, 1'b1, 12'h055, 1'b0);
    chk("post_rst_wr_en", {31'd0, wr_en}, 32'd1);
    chk("post_rst_addr", {22'd0, wr_addr}, 32'h000);
    chk("post_rst_data", {20'd0, wr_data}, 32'h055);
    chk("post_rst_drop", {24'd0, drop_cnt}, 32'd0);
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
